// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the memory access arbiter.
// Holds FSM state encodings, requester port ids and default widths.
package mem_access_arbiter_pkg;

    localparam int ARB_ADDR_W = 26;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_PORT_I = 1'b0,
        ARB_PORT_D = 1'b1
    } arb_port_e;

endpackage

// File: rtl/mem_access_arbiter_grant_pick.sv
// Combinational winner select between fetch and data requesters.
// Ports: i_req_i, d_req_i, last_i (last granted port) -> valid_o, port_o.
import mem_access_arbiter_pkg::*;

module mem_arb_grant_pick #(
    parameter bit RR_MODE = 1'b1
) (
    input  logic      i_req_i,
    input  logic      d_req_i,
    input  arb_port_e last_i,
    output logic      valid_o,
    output arb_port_e port_o
);

    always_comb begin
        valid_o = i_req_i | d_req_i;
        port_o  = ARB_PORT_D;
        unique case (1'b1)
            (i_req_i && !d_req_i): port_o = ARB_PORT_I;
            (!i_req_i && d_req_i): port_o = ARB_PORT_D;
            (i_req_i && d_req_i): begin
                // Tie: round-robin hands it to whoever did not win last.
                if (RR_MODE && last_i == ARB_PORT_D) begin
                    port_o = ARB_PORT_I;
                end else begin
                    port_o = ARB_PORT_D;
                end
            end
            default: port_o = ARB_PORT_D;
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates the single memory port between fetch (I) and load/store (D).
// Ports: CLK/RST, I_* fetch side, D_* data side, MEM_* memory side, BUSY.
import mem_access_arbiter_pkg::*;

module mem_access_arbiter #(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int MEM_LATENCY = 2,
    parameter bit RR_MODE     = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [DATA_W-1:0] I_RDATA,
    output logic              I_ACK,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_ACK,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_DATA_IN,
    input  logic [DATA_W-1:0] MEM_DATA_OUT,
    output logic              BUSY
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    arb_port_e         owner_q, owner_d;
    arb_port_e         last_q, last_d;
    logic [DATA_W-1:0] irdata_q, irdata_d;
    logic [DATA_W-1:0] drdata_q, drdata_d;

    logic      gnt_valid;
    arb_port_e gnt_port;

    mem_arb_grant_pick #(
        .RR_MODE (RR_MODE)
    ) u_pick (
        .i_req_i (I_REQ),
        .d_req_i (D_REQ),
        .last_i  (last_q),
        .valid_o (gnt_valid),
        .port_o  (gnt_port)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            owner_q  <= ARB_PORT_I;
            // Pointing at data makes the first tie go to fetch.
            last_q   <= ARB_PORT_D;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        last_d      = last_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        MEM_ADDR    = '0;
        MEM_READ    = 1'b0;
        MEM_WRITE   = 1'b0;
        MEM_DATA_IN = '0;
        I_ACK       = 1'b0;
        D_ACK       = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    state_d = ARB_ACCESS;
                    owner_d = gnt_port;
                    last_d  = gnt_port;
                    cnt_d   = CNT_LOAD;
                    if (gnt_port == ARB_PORT_D) begin
                        addr_d  = D_ADDR;
                        we_d    = D_WE;
                        wdata_d = D_WDATA;
                    end else begin
                        addr_d  = I_ADDR;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            ARB_ACCESS: begin
                MEM_ADDR    = addr_q;
                MEM_READ    = !we_q;
                MEM_WRITE   = we_q;
                MEM_DATA_IN = we_q ? wdata_q : '0;
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == ARB_PORT_D) begin
                            drdata_d = MEM_DATA_OUT;
                        end else begin
                            irdata_d = MEM_DATA_OUT;
                        end
                    end
                    state_d = ARB_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ARB_DONE: begin
                I_ACK   = (owner_q == ARB_PORT_I);
                D_ACK   = (owner_q == ARB_PORT_D);
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign I_RDATA = irdata_q;
    assign D_RDATA = drdata_q;
    assign BUSY    = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter (latency 2).
// One RR instance with a memory model, one fixed-priority instance.
module tb_mem_access_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_REQ, D_REQ, D_WE;
    logic [25:0] I_ADDR, D_ADDR;
    logic [31:0] D_WDATA;
    logic [31:0] I_RDATA, D_RDATA;
    logic        I_ACK, D_ACK;
    logic [25:0] MEM_ADDR;
    logic        MEM_READ, MEM_WRITE;
    logic [31:0] MEM_DATA_IN, MEM_DATA_OUT;
    logic        BUSY;

    logic        i_req0, d_req0;
    logic [31:0] i_rdata0, d_rdata0;
    logic        i_ack0, d_ack0;
    logic [25:0] mem_addr0;
    logic        mem_read0, mem_write0;
    logic [31:0] mem_din0;
    logic        busy0;

    int total = 0;
    int bad   = 0;
    logic overlap_seen;
    logic [31:0] mem [256];

    always #5 CLK = ~CLK;

    mem_access_arbiter #(
        .ADDR_W(26), .DATA_W(32), .MEM_LATENCY(2), .RR_MODE(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDATA(D_RDATA), .D_ACK(D_ACK),
        .MEM_ADDR(MEM_ADDR), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_DATA_IN(MEM_DATA_IN), .MEM_DATA_OUT(MEM_DATA_OUT), .BUSY(BUSY)
    );

    mem_access_arbiter #(
        .ADDR_W(26), .DATA_W(32), .MEM_LATENCY(2), .RR_MODE(1'b0)
    ) dut_fp (
        .CLK(CLK), .RST(RST),
        .I_REQ(i_req0), .I_ADDR(I_ADDR), .I_RDATA(i_rdata0), .I_ACK(i_ack0),
        .D_REQ(d_req0), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDATA(d_rdata0), .D_ACK(d_ack0),
        .MEM_ADDR(mem_addr0), .MEM_READ(mem_read0), .MEM_WRITE(mem_write0),
        .MEM_DATA_IN(mem_din0), .MEM_DATA_OUT(32'h0), .BUSY(busy0)
    );

    // Memory model: fetch address 0x0001000 holds 0xDEADBEEF.
    always @(posedge CLK) begin
        if (MEM_WRITE) mem[MEM_ADDR[7:0]] <= MEM_DATA_IN;
    end
    assign MEM_DATA_OUT = (MEM_ADDR == 26'h0001000) ? 32'hDEADBEEF
                                                     : mem[MEM_ADDR[7:0]];

    always @(negedge CLK) begin
        if (RST) overlap_seen <= 1'b0;
        else if ((MEM_READ && MEM_WRITE) || (mem_read0 && mem_write0))
            overlap_seen <= 1'b1;
        assert (!(MEM_READ && MEM_WRITE));
        assert (!(mem_read0 && mem_write0));
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        int acks;
        RST = 1'b1;
        I_REQ = 0; D_REQ = 0; D_WE = 0; i_req0 = 0; d_req0 = 0;
        I_ADDR = '0; D_ADDR = '0; D_WDATA = '0;
        #2;
        total++;
        if ({BUSY, I_ACK, D_ACK, MEM_READ, MEM_WRITE} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {BUSY, I_ACK, D_ACK, MEM_READ, MEM_WRITE});
        end
        total++;
        if ({MEM_ADDR, MEM_DATA_IN, I_RDATA, D_RDATA} !== 122'b0) begin
            bad++;
            $display("FAIL reset_bus got=%h/%h/%h/%h exp=0",
                     MEM_ADDR, MEM_DATA_IN, I_RDATA, D_RDATA);
        end
        tick; tick;
        RST = 1'b0;
        D_REQ = 1; D_WE = 1; D_ADDR = 26'h0000055; D_WDATA = 32'hA5A5A5A5;
        tick;
        total++;
        if (MEM_WRITE !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_write got=%b exp=1", MEM_WRITE);
        end
        #3 RST = 1'b1;
        #1;
        total++;
        if ({MEM_WRITE, BUSY, D_ACK} !== 3'b000) begin
            bad++;
            $display("FAIL rst_abort got=%b exp=000", {MEM_WRITE, BUSY, D_ACK});
        end
        D_REQ = 0; D_WE = 0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (D_ACK) acks++;
        end
        total++;
        if (acks !== 0) begin
            bad++;
            $display("FAIL rst_no_ack got=%0d exp=0", acks);
        end
        RST = 1'b0;
        tick;
    endtask

    task automatic test_single_fetch;
        I_REQ = 1; I_ADDR = 26'h0001000;
        tick;
        total++;
        if ({MEM_READ, MEM_WRITE, I_ACK, BUSY} !== 4'b1001 ||
            MEM_ADDR !== 26'h0001000) begin
            bad++;
            $display("FAIL fetch_c1 got=%b addr=%h exp=1001 addr=0001000",
                     {MEM_READ, MEM_WRITE, I_ACK, BUSY}, MEM_ADDR);
        end
        tick;
        total++;
        if ({MEM_READ, I_ACK} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_c2 got=%b exp=10", {MEM_READ, I_ACK});
        end
        tick;
        total++;
        if ({MEM_READ, I_ACK, D_ACK} !== 3'b010 || MEM_ADDR !== 26'h0 ||
            I_RDATA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL fetch_ack got=%b addr=%h rdata=%h exp=010 0 deadbeef",
                     {MEM_READ, I_ACK, D_ACK}, MEM_ADDR, I_RDATA);
        end
        I_REQ = 0;
        tick;
        total++;
        if ({I_ACK, BUSY} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_end got=%b exp=00", {I_ACK, BUSY});
        end
    endtask

    task automatic test_store_load;
        D_REQ = 1; D_WE = 1; D_ADDR = 26'h3FFFFF0; D_WDATA = 32'h12345678;
        tick;
        total++;
        if ({MEM_WRITE, MEM_READ} !== 2'b10 || MEM_ADDR !== 26'h3FFFFF0 ||
            MEM_DATA_IN !== 32'h12345678) begin
            bad++;
            $display("FAIL store_c1 got=%b addr=%h din=%h exp=10 3fffff0 12345678",
                     {MEM_WRITE, MEM_READ}, MEM_ADDR, MEM_DATA_IN);
        end
        tick;
        tick;
        total++;
        if ({MEM_WRITE, D_ACK, I_ACK} !== 3'b010 || MEM_DATA_IN !== 32'h0) begin
            bad++;
            $display("FAIL store_ack got=%b din=%h exp=010 0",
                     {MEM_WRITE, D_ACK, I_ACK}, MEM_DATA_IN);
        end
        D_REQ = 0;
        tick;
        D_REQ = 1; D_WE = 0; D_WDATA = 32'hFFFFFFFF;
        tick;
        total++;
        if ({MEM_READ, MEM_WRITE} !== 2'b10 || MEM_DATA_IN !== 32'h0) begin
            bad++;
            $display("FAIL load_c1 got=%b din=%h exp=10 0",
                     {MEM_READ, MEM_WRITE}, MEM_DATA_IN);
        end
        tick;
        tick;
        total++;
        if (D_ACK !== 1'b1 || D_RDATA !== 32'h12345678 ||
            I_RDATA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL load_ack got=%b d=%h i=%h exp=1 12345678 deadbeef",
                     D_ACK, D_RDATA, I_RDATA);
        end
        D_REQ = 0;
        tick;
    endtask

    task automatic test_rr;
        logic [3:0] ord_rr, ord_fp;
        int n_rr, n_fp;
        RST = 1'b1;
        #1 RST = 1'b0;
        I_ADDR = 26'h0001000; D_ADDR = 26'h3FFFFF0; D_WE = 0;
        I_REQ = 1; D_REQ = 1; i_req0 = 1; d_req0 = 1;
        n_rr = 0; n_fp = 0; ord_rr = '0; ord_fp = '0;
        for (int c = 0; c < 40 && (n_rr < 4 || n_fp < 4); c++) begin
            tick;
            if (n_rr < 4 && (I_ACK || D_ACK)) begin
                ord_rr[n_rr] = D_ACK;
                n_rr++;
                if (n_rr == 4) begin I_REQ = 0; D_REQ = 0; end
            end
            if (n_fp < 4 && (i_ack0 || d_ack0)) begin
                ord_fp[n_fp] = d_ack0;
                n_fp++;
                if (n_fp == 4) begin i_req0 = 0; d_req0 = 0; end
            end
        end
        I_REQ = 0; D_REQ = 0; i_req0 = 0; d_req0 = 0;
        total++;
        if (n_rr !== 4 || n_fp !== 4) begin
            bad++;
            $display("FAIL rr_timeout got=%0d/%0d exp=4/4", n_rr, n_fp);
        end
        // bit k = 1 means access k went to data; I,D,I,D -> 4'b1010
        total++;
        if (ord_rr !== 4'b1010) begin
            bad++;
            $display("FAIL rr_order got=%b exp=1010", ord_rr);
        end
        total++;
        if (ord_fp !== 4'b1111) begin
            bad++;
            $display("FAIL fp_order got=%b exp=1111", ord_fp);
        end
        tick; tick; tick;
        total++;
        if ({BUSY, busy0} !== 2'b00) begin
            bad++;
            $display("FAIL rr_idle got=%b exp=00", {BUSY, busy0});
        end
    endtask

    task automatic test_back_to_back;
        int ack_c [3];
        int n, strobes;
        n = 0; strobes = 0;
        D_REQ = 1; D_WE = 0; D_ADDR = 26'h3FFFFF0;
        for (int c = 1; c <= 40 && n < 3; c++) begin
            tick;
            if (MEM_READ) strobes++;
            if (D_ACK) begin
                ack_c[n] = c;
                n++;
                if (n == 3) D_REQ = 0;
            end
        end
        D_REQ = 0;
        total++;
        if (n !== 3) begin
            bad++;
            $display("FAIL b2b_timeout got=%0d exp=3", n);
        end else begin
            total++;
            if (ack_c[0] !== 3) begin
                bad++;
                $display("FAIL b2b_first got=%0d exp=3", ack_c[0]);
            end
            total++;
            if (ack_c[1] - ack_c[0] !== 4 || ack_c[2] - ack_c[1] !== 4) begin
                bad++;
                $display("FAIL b2b_gap got=%0d,%0d exp=4,4",
                         ack_c[1] - ack_c[0], ack_c[2] - ack_c[1]);
            end
        end
        total++;
        if (strobes !== 6 || D_RDATA !== 32'h12345678) begin
            bad++;
            $display("FAIL b2b_data got=%0d %h exp=6 12345678", strobes, D_RDATA);
        end
        total++;
        if (overlap_seen !== 1'b0) begin
            bad++;
            $display("FAIL rw_overlap got=%b exp=0", overlap_seen);
        end
        tick; tick;
    endtask

    task automatic test_req_drop;
        int iacks, dacks, strobes;
        iacks = 0; dacks = 0; strobes = 0;
        I_REQ = 1; I_ADDR = 26'h0001000;
        tick;
        I_REQ = 0;
        I_ADDR = 26'h0000077;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (I_ACK) iacks++;
            if (D_ACK) dacks++;
            if (MEM_READ || MEM_WRITE) strobes++;
        end
        total++;
        if (iacks !== 1 || dacks !== 0 || strobes !== 1) begin
            bad++;
            $display("FAIL req_drop got=%0d/%0d/%0d exp=1/0/1",
                     iacks, dacks, strobes);
        end
        total++;
        if (BUSY !== 1'b0 || I_RDATA !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL req_drop_end got=%b %h exp=0 deadbeef", BUSY, I_RDATA);
        end
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_store_load;
        test_rr;
        test_back_to_back;
        test_req_drop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
